// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   The instruction-fetch port and the mem-stage data port share one
//   single-port memory through this block. It issues each access as a
//   registered bus transaction and returns read data with a one-cycle ready
//   pulse. While either port is waiting it drives the pipeline stall vector.
//   The data port has fixed priority over fetch, because it belongs to the
//   older instruction.
//
// Parameters
//   ADDR_W   address width of both ports and the memory bus
//   DATA_W   data width of both ports and the memory bus
//   TIMEOUT  busy cycles without mem_ack before an access is aborted
//            (0 = wait forever)
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   if_req/if_addr            fetch request (read only), held until if_ready
//   if_rdata/if_ready         fetched word, valid with the one-cycle pulse
//   dm_req/dm_we/dm_sel/
//   dm_addr/dm_wdata          data request, held until dm_ready
//   dm_rdata/dm_ready         read data, valid with the one-cycle pulse
//   bus_err                   pulses with a ready that ended by timeout
//   mem_ce/mem_we/mem_sel/
//   mem_addr/mem_wdata        registered memory bus outputs
//   mem_rdata/mem_ack         memory response
//   stall                     {wb,mem,ex,id,if,pc} hold vector
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_sel,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              bus_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [5:0]        stall
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               dm_elig;
    logic               if_elig;
    logic               timeout_hit;

    // A port whose ready is high in this cycle was just served. Masking it
    // stops the still-held request from being issued a second time.
    assign dm_elig = dm_req & ~dm_ready;
    assign if_elig = if_req & ~if_ready;

    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dm_rdata  <= '0;
            if_rdata  <= '0;
            dm_ready  <= 1'b0;
            if_ready  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            dm_ready <= 1'b0;
            if_ready <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Any mem_ack seen here is stray and is ignored.
                    cnt <= '0;
                    if (dm_elig) begin
                        state     <= DM_BUSY;
                        mem_ce    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_sel   <= dm_sel;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_elig) begin
                        state     <= IF_BUSY;
                        mem_ce    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_sel   <= 4'hF;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                DM_BUSY, IF_BUSY: begin
                    if (mem_ack || timeout_hit) begin
                        // The transaction ends. Going back to IDLE leaves at
                        // least one idle cycle before the next issue.
                        state   <= IDLE;
                        mem_ce  <= 1'b0;
                        mem_we  <= 1'b0;
                        cnt     <= '0;
                        bus_err <= ~mem_ack;
                        if (state == DM_BUSY) begin
                            dm_ready <= 1'b1;
                            if (!mem_ack)
                                dm_rdata <= '0;
                            else if (!mem_we)
                                dm_rdata <= mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_ce <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // The stall vector drops in the ready cycle itself, so the pipeline
    // advances on the same edge at which the requester consumes the data.
    always_comb begin
        stall = 6'b000000;
        if (dm_req & ~dm_ready)
            stall = 6'b011111;
        else if (if_req & ~if_ready)
            stall = 6'b000011;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by randomized jobs. The bench plans each job
//   as a timeline: when each port's access occupies the bus, when it
//   completes, and what data it returns. It works this out from the
//   arbitration, latency and timeout rules. It then plays the memory against
//   that plan and compares every cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_sel;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          bus_err;
    logic          mem_ce;
    logic          mem_we;
    logic [3:0]    mem_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [5:0]    stall;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .bus_err(bus_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_dm_rdata = '0;
    logic [DW-1:0] exp_if_rdata = '0;
    logic [DW-1:0] mem_m [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory contents: unwritten words read back an address-derived pattern.
    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        logic [DW-1:0] v;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        mem_m[a] = v;
    endtask

    // One job: optional data access and/or fetch, both requested in cycle 0.
    // k_* is the memory latency in cycles after mem_ce rises; k >= TO never acks.
    task automatic run_job(input bit do_dm, input bit we, input logic [3:0] sel,
                           input logic [AW-1:0] daddr, input logic [DW-1:0] wdata,
                           input int k_dm, input bit do_if, input logic [AW-1:0] iaddr,
                           input int k_if, input int gap);
        int            d_dm, d_if, dm_rdy, if_rdy, if_n, last;
        bit            dm_ce_t, if_ce_t, ack_t, err_t;
        logic [5:0]    exp_stall;
        logic [DW-1:0] dm_val, if_val;
        d_dm   = (k_dm < TO) ? k_dm + 1 : TO;
        d_if   = (k_if < TO) ? k_if + 1 : TO;
        dm_rdy = do_dm ? d_dm + 1 : -1;
        if_n   = do_dm ? dm_rdy : 0;  // fetch waits for the data access's ready cycle
        if_rdy = do_if ? if_n + d_if + 1 : -1;
        last   = ((dm_rdy > if_rdy) ? dm_rdy : if_rdy) + gap;
        dm_val = '0;
        if_val = '0;
        for (int t = 0; t <= last; t++) begin
            @(posedge clk);
            #1;
            dm_ce_t = do_dm && t >= 1 && t <= d_dm;
            if_ce_t = do_if && t >= if_n + 1 && t <= if_n + d_if;
            if (do_dm && t == dm_rdy) begin
                if (k_dm >= TO) exp_dm_rdata = '0;
                else if (!we) exp_dm_rdata = dm_val;
            end
            if (do_if && t == if_rdy) exp_if_rdata = (k_if >= TO) ? '0 : if_val;
            err_t = (do_dm && t == dm_rdy && k_dm >= TO) || (do_if && t == if_rdy && k_if >= TO);
            chk("mem_ce", 64'(mem_ce), 64'(dm_ce_t | if_ce_t));
            if (dm_ce_t) begin
                chk("dm_mem_we", 64'(mem_we), 64'(we));
                chk("dm_mem_sel", 64'(mem_sel), 64'(sel));
                chk("dm_mem_addr", 64'(mem_addr), 64'(daddr));
                chk("dm_mem_wdata", 64'(mem_wdata), 64'(wdata));
            end else if (if_ce_t) begin
                chk("if_mem_we", 64'(mem_we), 64'(1'b0));
                chk("if_mem_sel", 64'(mem_sel), 64'(4'hF));
                chk("if_mem_addr", 64'(mem_addr), 64'(iaddr));
                chk("if_mem_wdata", 64'(mem_wdata), 64'(0));
            end else begin
                chk("mem_we_idle", 64'(mem_we), 64'(1'b0));
            end
            chk("dm_ready", 64'(dm_ready), 64'(do_dm && t == dm_rdy));
            chk("if_ready", 64'(if_ready), 64'(do_if && t == if_rdy));
            chk("bus_err", 64'(bus_err), 64'(err_t));
            chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
            chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));

            // Requesters hold req through their ready cycle, then drop it.
            dm_req   = do_dm && t <= dm_rdy;
            if_req   = do_if && t <= if_rdy;
            dm_we    = we;
            dm_sel   = sel;
            dm_addr  = daddr;
            dm_wdata = wdata;
            if_addr  = iaddr;
            ack_t     = 1'b0;
            mem_rdata = $urandom;
            if (do_dm && k_dm < TO && t == 1 + k_dm) begin
                ack_t     = 1'b1;
                dm_val    = mem_rd(daddr);
                mem_rdata = dm_val;
                if (we) mem_wr(daddr, wdata, sel);
            end
            if (do_if && k_if < TO && t == if_n + 1 + k_if) begin
                ack_t     = 1'b1;
                if_val    = mem_rd(iaddr);
                mem_rdata = if_val;
            end
            if (!dm_ce_t && !if_ce_t && $urandom_range(0, 3) == 0) ack_t = 1'b1;  // stray ack
            mem_ack = ack_t;
            #1;
            if (do_dm && t < dm_rdy) exp_stall = 6'b011111;
            else if (do_if && t < if_rdy) exp_stall = 6'b000011;
            else exp_stall = 6'b000000;
            chk("stall", 64'(stall), 64'(exp_stall));
        end
    endtask

    initial begin
        int            sc, kd, ki, gp;
        bit            rwe;
        logic [3:0]    rsel;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] rw;

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_sel = 4'h0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_ce", 64'(mem_ce), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_sel", 64'(mem_sel), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_dm_rdata", 64'(dm_rdata), 64'(0));
        chk("rst_if_rdata", 64'(if_rdata), 64'(0));
        chk("rst_dm_ready", 64'(dm_ready), 64'(0));
        chk("rst_if_ready", 64'(if_ready), 64'(0));
        chk("rst_bus_err", 64'(bus_err), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        rst = 1'b1;

        // Fetch, ack one cycle after ce.
        mem_m[32'h0000_0040] = 32'h3401_1100;
        run_job(1'b0, 1'b0, 4'h0, '0, '0, 0, 1'b1, 32'h0000_0040, 1, 2);
        // Partial write, ack in the first ce cycle.
        run_job(1'b1, 1'b1, 4'b0011, 32'h0000_1000, 32'hCAFE_F00D, 0, 1'b0, '0, 0, 2);
        // Simultaneous requests: data read first, then fetch.
        run_job(1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1, 1'b1, 32'h0000_0040, 0, 2);
        // Data read that never gets an ack.
        run_job(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 100, 1'b0, '0, 0, 2);
        // Fetch that never gets an ack.
        run_job(1'b0, 1'b0, 4'h0, '0, '0, 0, 1'b1, 32'h0000_0044, 100, 2);

        // Reset while the data port is busy.
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0200; mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("busy_mem_ce", 64'(mem_ce), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_mem_ce", 64'(mem_ce), 64'(0));
        chk("arst_mem_we", 64'(mem_we), 64'(0));
        chk("arst_dm_ready", 64'(dm_ready), 64'(0));
        chk("arst_dm_rdata", 64'(dm_rdata), 64'(0));
        chk("arst_if_rdata", 64'(if_rdata), 64'(0));
        exp_dm_rdata = '0;
        exp_if_rdata = '0;
        dm_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("post_rst_dm_ready", 64'(dm_ready), 64'(0));
            chk("post_rst_mem_ce", 64'(mem_ce), 64'(0));
        end
        run_job(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 2, 1'b0, '0, 0, 1);

        // Randomized jobs over a small address pool so reads see earlier writes.
        for (int j = 0; j < 250; j++) begin
            sc   = $urandom_range(0, 2);
            rwe  = 1'($urandom_range(0, 1));
            rsel = 4'($urandom_range(1, 15));
            ra   = 32'($urandom_range(0, 15)) << 2;
            rb   = 32'($urandom_range(0, 15)) << 2;
            rw   = $urandom;
            kd   = $urandom_range(0, 9);
            if (kd > 5) kd = $urandom_range(0, 2);
            ki   = $urandom_range(0, 9);
            if (ki > 5) ki = $urandom_range(0, 2);
            gp   = $urandom_range(1, 3);
            run_job(sc != 1, rwe, rsel, ra, rw, kd, sc != 0, rb, ki, gp);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
